// File: rtl/rle_run_tracker.sv
// Streaming per-line longest-run tracker for NUM_CH binary colour masks.
// Bridges background gaps up to MAX_GAP pixels and drops runs shorter than MIN_RUN.
module rle_run_tracker #(
  parameter int unsigned IMAGE_W = 640,
  parameter int unsigned IMAGE_H = 480,
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned MIN_RUN = 60,
  parameter int unsigned MAX_GAP = 2,
  localparam int unsigned XW = $clog2(IMAGE_W + 1),
  localparam int unsigned YW = (IMAGE_H > 1) ? $clog2(IMAGE_H) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 pix_valid,
  input  logic                 pix_sof,
  input  logic [NUM_CH-1:0]    pix_in,
  output logic                 line_valid,
  output logic [YW-1:0]        line_idx,
  output logic                 frame_done,
  output logic [NUM_CH-1:0]    run_found,
  output logic [NUM_CH*XW-1:0] run_start,
  output logic [NUM_CH*XW-1:0] run_len
);

  localparam int unsigned GW = $clog2(MAX_GAP + 2);
  localparam logic [XW-1:0] X_LAST  = XW'(IMAGE_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMAGE_H - 1);
  localparam logic [GW-1:0] GAP_SAT = GW'(MAX_GAP + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(MAX_GAP);

  // Position counters
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  // Per-channel run state
  logic          open_q  [NUM_CH];
  logic [XW-1:0] cs_q    [NUM_CH];
  logic [XW-1:0] lf_q    [NUM_CH];
  logic [GW-1:0] gap_q   [NUM_CH];
  logic [XW-1:0] bs_q    [NUM_CH];
  logic [XW-1:0] bl_q    [NUM_CH];

  logic          open_d  [NUM_CH];
  logic [XW-1:0] cs_d    [NUM_CH];
  logic [XW-1:0] lf_d    [NUM_CH];
  logic [GW-1:0] gap_d   [NUM_CH];
  logic [XW-1:0] bs_d    [NUM_CH];
  logic [XW-1:0] bl_d    [NUM_CH];
  logic          close_c [NUM_CH];
  logic [XW-1:0] clen_c  [NUM_CH];

  // Registered results
  logic                 line_valid_q;
  logic [YW-1:0]        line_idx_q;
  logic                 frame_done_q;
  logic [NUM_CH-1:0]    run_found_q;
  logic [NUM_CH*XW-1:0] run_start_q;
  logic [NUM_CH*XW-1:0] run_len_q;

  logic [XW-1:0]        x_cur_c;
  logic [YW-1:0]        y_cur_c;
  logic                 last_c;
  logic [NUM_CH-1:0]    found_c;
  logic [NUM_CH*XW-1:0] start_c;
  logic [NUM_CH*XW-1:0] len_c;

  assign line_valid = line_valid_q;
  assign line_idx   = line_idx_q;
  assign frame_done = frame_done_q;
  assign run_found  = run_found_q;
  assign run_start  = run_start_q;
  assign run_len    = run_len_q;

  // Per-pixel run update; a start-of-frame pixel sees cleared state.
  always_comb begin
    x_cur_c = pix_sof ? '0 : x_q;
    y_cur_c = pix_sof ? '0 : y_q;
    last_c  = (x_cur_c == X_LAST);
    found_c = '0;
    start_c = '0;
    len_c   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      open_d[c]  = pix_sof ? 1'b0 : open_q[c];
      cs_d[c]    = pix_sof ? '0 : cs_q[c];
      lf_d[c]    = pix_sof ? '0 : lf_q[c];
      gap_d[c]   = pix_sof ? '0 : gap_q[c];
      bs_d[c]    = pix_sof ? '0 : bs_q[c];
      bl_d[c]    = pix_sof ? '0 : bl_q[c];
      close_c[c] = 1'b0;

      if (pix_in[c]) begin
        if (!open_d[c]) begin
          open_d[c] = 1'b1;
          cs_d[c]   = x_cur_c;
        end
        lf_d[c]  = x_cur_c;
        gap_d[c] = '0;
      end else if (open_d[c]) begin
        if (gap_d[c] != GAP_SAT) begin
          gap_d[c] = gap_d[c] + GW'(1);
        end
        if (gap_d[c] > GAP_MAX) begin
          close_c[c] = 1'b1;
        end
      end

      // End of line forces a close; a gap close on the same pixel is the same event.
      if (last_c && open_d[c]) begin
        close_c[c] = 1'b1;
      end
      if (close_c[c]) begin
        open_d[c] = 1'b0;
        gap_d[c]  = '0;
      end

      clen_c[c] = lf_d[c] - cs_d[c] + XW'(1);
      if (close_c[c] && (clen_c[c] > bl_d[c])) begin
        bs_d[c] = cs_d[c];
        bl_d[c] = clen_c[c];
      end

      if (32'(bl_d[c]) >= MIN_RUN) begin
        found_c[c]            = 1'b1;
        start_c[c*XW +: XW]   = bs_d[c];
        len_c[c*XW +: XW]     = bl_d[c];
      end
    end
  end

  // State and result registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      x_q          <= '0;
      y_q          <= '0;
      line_valid_q <= 1'b0;
      line_idx_q   <= '0;
      frame_done_q <= 1'b0;
      run_found_q  <= '0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        open_q[c] <= 1'b0;
        cs_q[c]   <= '0;
        lf_q[c]   <= '0;
        gap_q[c]  <= '0;
        bs_q[c]   <= '0;
        bl_q[c]   <= '0;
      end
    end else begin
      line_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      if (pix_valid) begin
        for (int c = 0; c < NUM_CH; c++) begin
          open_q[c] <= open_d[c];
          cs_q[c]   <= cs_d[c];
          lf_q[c]   <= lf_d[c];
          gap_q[c]  <= gap_d[c];
          bs_q[c]   <= last_c ? '0 : bs_d[c];
          bl_q[c]   <= last_c ? '0 : bl_d[c];
        end
        if (last_c) begin
          x_q          <= '0;
          y_q          <= (y_cur_c == Y_LAST) ? '0 : y_cur_c + YW'(1);
          line_valid_q <= 1'b1;
          line_idx_q   <= y_cur_c;
          frame_done_q <= (y_cur_c == Y_LAST);
          run_found_q  <= found_c;
          run_start_q  <= start_c;
          run_len_q    <= len_c;
        end else begin
          x_q <= x_cur_c + XW'(1);
          y_q <= y_cur_c;
        end
      end
    end
  end

endmodule
